// File: rtl/leb128_fetch.sv
// leb128_fetch: sequential signed-LEB128 immediate fetch unit.
// Reads a varint32/varint64 one byte per cycle from a byte-wide ROM with
// one cycle of read latency and returns the sign-extended value, the
// encoded length and an error flag.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      decode request, accepted while ready=1
//   addr       address of the first encoded byte (sampled with start)
//   is64       0: varint32 (max 5 bytes), 1: varint64 (max 10 bytes)
//   ready      idle, can accept start
//   mem_rd     ROM read strobe
//   mem_addr   ROM byte address
//   mem_data   ROM byte, valid the cycle after the address edge
//   mem_error  ROM out-of-range flag, same timing as mem_data
//   done       one-cycle pulse, result outputs valid
//   value      decoded value, sign-extended to 64 bits
//   len        bytes consumed (1..10)
//   error      malformed, over-long or ROM error
module leb128_fetch #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic              is64,
    output logic              ready,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    input  logic              mem_error,
    output logic              done,
    output logic [63:0]       value,
    output logic [3:0]        len,
    output logic              error
);

    localparam int unsigned VAL_W = 64;
    localparam int unsigned LEN_W = 4;
    localparam int unsigned SH_W  = 7;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    // Index of the final permitted byte for each width.
    localparam logic [LEN_W-1:0] LAST_K32 = 4'd4;
    localparam logic [LEN_W-1:0] LAST_K64 = 4'd9;

    logic              state,    state_nxt;
    logic              is64_q,   is64_nxt;
    logic              ready_nxt;
    logic              mem_rd_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [VAL_W-1:0]  acc,      acc_nxt;
    logic [SH_W-1:0]   shamt,    shamt_nxt;
    logic [LEN_W-1:0]  cnt,      cnt_nxt;
    logic [LEN_W-1:0]  issued,   issued_nxt;
    logic              primed,   primed_nxt;
    logic              done_nxt;
    logic [VAL_W-1:0]  value_nxt;
    logic [LEN_W-1:0]  len_nxt;
    logic              error_nxt;

    // Byte-decode intermediates for the byte currently on mem_data.
    logic [LEN_W-1:0]  last_k;
    logic [LEN_W-1:0]  max_len;
    logic [VAL_W-1:0]  acc_cur;
    logic [SH_W-1:0]   shamt_end;
    logic [VAL_W-1:0]  ext_mask;
    logic [VAL_W-1:0]  sext;
    logic              at_max;
    logic              canon_ok;
    logic              term;
    logic              term_err;
    logic [VAL_W-1:0]  term_val;

    // Decode of the byte on mem_data against the running accumulator.
    always_comb begin
        last_k    = is64_q ? LAST_K64 : LAST_K32;
        max_len   = LEN_W'(last_k + 4'd1);
        acc_cur   = acc | (VAL_W'(mem_data[6:0]) << shamt);
        shamt_end = SH_W'(shamt + 7'd7);
        at_max    = (cnt == last_k);
        ext_mask  = '0;
        term      = 1'b0;
        term_err  = 1'b0;
        term_val  = '0;

        // Sign bit of the final group only extends if there are bits above it.
        if (mem_data[6] && (shamt_end < 7'd64)) begin
            ext_mask = {VAL_W{1'b1}} << shamt_end;
        end
        sext = acc_cur | ext_mask;
        if (!is64_q) begin
            sext = {{32{sext[31]}}, sext[31:0]};
        end

        // Unused high bits of the final byte must agree with the sign.
        canon_ok = 1'b1;
        if (at_max) begin
            if (is64_q) begin
                canon_ok = (mem_data[6:0] == 7'h00) || (mem_data[6:0] == 7'h7F);
            end else begin
                canon_ok = (mem_data[6:3] == 4'h0) || (mem_data[6:3] == 4'hF);
            end
        end

        if (mem_error) begin
            term     = 1'b1;
            term_err = 1'b1;
        end else if (!mem_data[7]) begin
            term     = 1'b1;
            term_err = !canon_ok;
            term_val = canon_ok ? sext : '0;
        end else if (at_max) begin
            term     = 1'b1;
            term_err = 1'b1;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_nxt    = state;
        is64_nxt     = is64_q;
        ready_nxt    = ready;
        mem_rd_nxt   = mem_rd;
        mem_addr_nxt = mem_addr;
        acc_nxt      = acc;
        shamt_nxt    = shamt;
        cnt_nxt      = cnt;
        issued_nxt   = issued;
        primed_nxt   = primed;
        done_nxt     = 1'b0;
        value_nxt    = value;
        len_nxt      = len;
        error_nxt    = error;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt    = ST_RUN;
                    ready_nxt    = 1'b0;
                    is64_nxt     = is64;
                    mem_addr_nxt = addr;
                    mem_rd_nxt   = 1'b1;
                    acc_nxt      = '0;
                    shamt_nxt    = '0;
                    cnt_nxt      = '0;
                    issued_nxt   = 4'd1;
                    primed_nxt   = 1'b0;
                end
            end
            ST_RUN: begin
                // Keep one read in flight; never read past the maximum length.
                if (issued < max_len) begin
                    mem_addr_nxt = mem_addr + ADDR_W'(1);
                    mem_rd_nxt   = 1'b1;
                    issued_nxt   = LEN_W'(issued + 4'd1);
                end else begin
                    mem_rd_nxt   = 1'b0;
                end

                // First RUN edge only launches the pipeline; no data yet.
                if (!primed) begin
                    primed_nxt = 1'b1;
                end else if (term) begin
                    state_nxt    = ST_IDLE;
                    ready_nxt    = 1'b1;
                    done_nxt     = 1'b1;
                    mem_rd_nxt   = 1'b0;
                    mem_addr_nxt = mem_addr;
                    issued_nxt   = issued;
                    value_nxt    = term_val;
                    len_nxt      = LEN_W'(cnt + 4'd1);
                    error_nxt    = term_err;
                end else begin
                    acc_nxt   = acc_cur;
                    shamt_nxt = shamt_end;
                    cnt_nxt   = LEN_W'(cnt + 4'd1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                ready_nxt = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            is64_q   <= 1'b0;
            ready    <= 1'b1;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            acc      <= '0;
            shamt    <= '0;
            cnt      <= '0;
            issued   <= '0;
            primed   <= 1'b0;
            done     <= 1'b0;
            value    <= '0;
            len      <= '0;
            error    <= 1'b0;
        end else begin
            state    <= state_nxt;
            is64_q   <= is64_nxt;
            ready    <= ready_nxt;
            mem_rd   <= mem_rd_nxt;
            mem_addr <= mem_addr_nxt;
            acc      <= acc_nxt;
            shamt    <= shamt_nxt;
            cnt      <= cnt_nxt;
            issued   <= issued_nxt;
            primed   <= primed_nxt;
            done     <= done_nxt;
            value    <= value_nxt;
            len      <= len_nxt;
            error    <= error_nxt;
        end
    end

endmodule

// File: tb/tb_leb128_fetch.sv
// Testbench for leb128_fetch: table of directed encodings plus hand-written
// sequences for reset, ROM error, start-during-RUN and back-to-back starts.
module tb_leb128_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  addr;
    logic        is64;
    logic        ready;
    logic        mem_rd;
    logic [3:0]  mem_addr;
    logic [7:0]  mem_data = 8'h00;
    logic        mem_error = 1'b0;
    logic        done;
    logic [63:0] value;
    logic [3:0]  len;
    logic        error;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] rom [16];
    logic       err_map [16];

    leb128_fetch #(.ADDR_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .addr      (addr),
        .is64      (is64),
        .ready     (ready),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_error (mem_error),
        .done      (done),
        .value     (value),
        .len       (len),
        .error     (error)
    );

    always #5 clk = ~clk;

    // ROM with one cycle of read latency.
    always @(posedge clk) begin
        mem_data  <= rom[mem_addr];
        mem_error <= mem_rd & err_map[mem_addr];
    end

    typedef struct {
        logic        is64;
        logic [3:0]  addr;
        int          nb;
        logic [79:0] bytes;   // first byte in the most significant used position
        logic [63:0] ev;
        logic [3:0]  el;
        logic        ee;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic i64, input logic [3:0] a, input int n,
                                input logic [79:0] b, input logic [63:0] ev,
                                input logic [3:0] el, input logic ee);
        vec_t v;
        v.is64 = i64; v.addr = a; v.nb = n; v.bytes = b;
        v.ev = ev; v.el = el; v.ee = ee;
        return v;
    endfunction

    function void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endfunction

    task automatic load(input logic [3:0] a, input int n, input logic [79:0] b);
        for (int j = 0; j < n; j++) begin
            rom[4'(a + 4'(j))] = b[8*(n-1-j) +: 8];
        end
    endtask

    // Waits (bounded) for done; lat counts negedges from the one after E0.
    task automatic wait_done(output int lat, output int reads, output logic ok,
                             output int busy_rdy);
        lat = 0; reads = 0; ok = 1'b0; busy_rdy = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (mem_rd) reads++;
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (ready) busy_rdy++;
        end
    endtask

    initial begin
        int lat, reads, busy_rdy, maxb;
        logic ok;
        logic [63:0] lastv;

        for (int i = 0; i < 16; i++) begin
            rom[i] = 8'h00;
            err_map[i] = 1'b0;
        end
        reset = 1'b0; start = 1'b0; addr = '0; is64 = 1'b0;

        vecs.push_back(mk(0, 4'd0,  1, 80'h02, 64'd2, 4'd1, 0));
        vecs.push_back(mk(0, 4'd3,  3, 80'hE58E26, 64'h98765, 4'd3, 0));
        vecs.push_back(mk(0, 4'd5,  1, 80'h7F, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 0));
        vecs.push_back(mk(1, 4'd0,  2, 80'h807F, 64'hFFFF_FFFF_FFFF_FF80, 4'd2, 0));
        vecs.push_back(mk(1, 4'd2, 10, 80'h8080_8080_8080_8080_807F, 64'h8000_0000_0000_0000, 4'd10, 0));
        vecs.push_back(mk(0, 4'd0,  5, 80'h80_8080_8080, 64'd0, 4'd5, 1));
        vecs.push_back(mk(0, 4'd0,  5, 80'h80_8080_8070, 64'd0, 4'd5, 1));
        vecs.push_back(mk(1, 4'd0, 10, 80'h8080_8080_8080_8080_8002, 64'd0, 4'd10, 1));
        vecs.push_back(mk(1, 4'd9, 10, 80'h8080_8080_8080_8080_8000, 64'd0, 4'd10, 0));
        vecs.push_back(mk(0, 4'd14, 5, 80'hFF_FFFF_FF7F, 64'hFFFF_FFFF_FFFF_FFFF, 4'd5, 0));
        vecs.push_back(mk(0, 4'd1,  5, 80'hFF_FFFF_FF07, 64'h0000_0000_7FFF_FFFF, 4'd5, 0));
        vecs.push_back(mk(1, 4'd6,  3, 80'hE58E26, 64'h98765, 4'd3, 0));
        vecs.push_back(mk(0, 4'd0,  5, 80'hFF_FFFF_FF0F, 64'd0, 4'd5, 1));
        vecs.push_back(mk(1, 4'd0, 10, 80'h8080_8080_8080_8080_8080, 64'd0, 4'd10, 1));
        vecs.push_back(mk(0, 4'd7,  3, 80'hC0BB78, 64'hFFFF_FFFF_FFFE_1DC0, 4'd3, 0));

        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst ready", 64'(ready), 64'd1);
        chk("rst mem_rd", 64'(mem_rd), 64'd0);
        chk("rst mem_addr", 64'(mem_addr), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst value", value, 64'd0);
        chk("rst len", 64'(len), 64'd0);
        chk("rst error", 64'(error), 64'd0);

        // Address/strobe sequence of a one-byte decode
        load(4'd0, 1, 80'h02);
        start = 1'b1; addr = 4'd0; is64 = 1'b0;
        @(negedge clk); start = 1'b0;
        chk("seq N1 mem_addr", 64'(mem_addr), 64'd0);
        chk("seq N1 mem_rd", 64'(mem_rd), 64'd1);
        chk("seq N1 ready", 64'(ready), 64'd0);
        @(negedge clk);
        chk("seq N2 mem_addr", 64'(mem_addr), 64'd1);
        chk("seq N2 mem_rd", 64'(mem_rd), 64'd1);
        chk("seq N2 done", 64'(done), 64'd0);
        @(negedge clk);
        chk("seq N3 done", 64'(done), 64'd1);
        chk("seq N3 value", value, 64'd2);
        chk("seq N3 ready", 64'(ready), 64'd1);
        @(negedge clk);
        chk("seq N4 done", 64'(done), 64'd0);
        chk("seq N4 mem_rd", 64'(mem_rd), 64'd0);

        // Table-driven vectors
        lastv = '0;
        foreach (vecs[i]) begin
            @(negedge clk);
            load(vecs[i].addr, vecs[i].nb, vecs[i].bytes);
            start = 1'b1; addr = vecs[i].addr; is64 = vecs[i].is64;
            wait_done(lat, reads, ok, busy_rdy);
            maxb = vecs[i].is64 ? 10 : 5;
            chk($sformatf("v%0d done seen", i), 64'(ok), 64'd1);
            chk($sformatf("v%0d value", i), value, vecs[i].ev);
            chk($sformatf("v%0d len", i), 64'(len), 64'(vecs[i].el));
            chk($sformatf("v%0d error", i), 64'(error), 64'(vecs[i].ee));
            chk($sformatf("v%0d latency", i), 64'(lat - 1), 64'(vecs[i].nb + 1));
            chk($sformatf("v%0d reads", i), 64'(reads),
                64'((vecs[i].nb < maxb) ? vecs[i].nb + 1 : vecs[i].nb));
            chk($sformatf("v%0d ready at done", i), 64'(ready), 64'd1);
            chk($sformatf("v%0d ready while busy", i), 64'(busy_rdy), 64'd0);
            lastv = vecs[i].ev;
        end

        // Result held, done is a single pulse
        repeat (3) @(negedge clk);
        chk("hold done", 64'(done), 64'd0);
        chk("hold value", value, lastv);

        // ROM error on byte 1, with a stray start during RUN
        load(4'd4, 3, 80'h808001);
        err_map[5] = 1'b1;
        @(negedge clk);
        start = 1'b1; addr = 4'd4; is64 = 1'b0;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; addr = 4'd0; is64 = 1'b1;
        wait_done(lat, reads, ok, busy_rdy);
        chk("merr done seen", 64'(ok), 64'd1);
        chk("merr error", 64'(error), 64'd1);
        chk("merr len", 64'(len), 64'd2);
        chk("merr value", value, 64'd0);
        chk("merr latency", 64'(lat + 2 - 1), 64'd3);
        @(negedge clk);
        chk("merr stray start ignored", 64'(mem_rd), 64'd0);
        chk("merr idle ready", 64'(ready), 64'd1);
        err_map[5] = 1'b0;

        // Back-to-back: second start sampled in the done cycle
        load(4'd0, 1, 80'h01);
        load(4'd8, 2, 80'h807F);
        @(negedge clk);
        start = 1'b1; addr = 4'd0; is64 = 1'b0;
        wait_done(lat, reads, ok, busy_rdy);
        chk("b2b first value", value, 64'd1);
        start = 1'b1; addr = 4'd8; is64 = 1'b1;
        wait_done(lat, reads, ok, busy_rdy);
        chk("b2b second done", 64'(ok), 64'd1);
        chk("b2b second value", value, 64'hFFFF_FFFF_FFFF_FF80);
        chk("b2b second len", 64'(len), 64'd2);
        chk("b2b second latency", 64'(lat - 1), 64'd3);

        // Reset mid-decode
        load(4'd0, 3, 80'h808001);
        @(negedge clk);
        start = 1'b1; addr = 4'd0; is64 = 1'b0;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst ready", 64'(ready), 64'd1);
        chk("midrst mem_rd", 64'(mem_rd), 64'd0);
        chk("midrst mem_addr", 64'(mem_addr), 64'd0);
        chk("midrst value", value, 64'd0);
        chk("midrst len", 64'(len), 64'd0);
        chk("midrst error", 64'(error), 64'd0);
        busy_rdy = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) busy_rdy++;
        end
        chk("midrst no done", 64'(busy_rdy), 64'd0);
        reset = 1'b1;
        load(4'd0, 1, 80'h01);
        @(negedge clk);
        start = 1'b1; addr = 4'd0; is64 = 1'b0;
        wait_done(lat, reads, ok, busy_rdy);
        chk("postrst done", 64'(ok), 64'd1);
        chk("postrst value", value, 64'd1);
        chk("postrst len", 64'(len), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
